// File: rtl/boa_gpio_pkg.sv
// boa_gpio_pkg: register map offsets, per-pin config layout and lane-mask helper for boa_peri_gpio_irq
package boa_gpio_pkg;
    localparam logic [7:0] OFF_IN   = 8'h00;
    localparam logic [7:0] OFF_OUT  = 8'h04;
    localparam logic [7:0] OFF_SET  = 8'h08;
    localparam logic [7:0] OFF_CLR  = 8'h0C;
    localparam logic [7:0] OFF_TGL  = 8'h10;
    localparam logic [7:0] OFF_OE   = 8'h14;
    localparam logic [7:0] OFF_EN   = 8'h18;
    localparam logic [7:0] OFF_STAT = 8'h1C;
    localparam logic [7:0] OFF_RISE = 8'h20;
    localparam logic [7:0] OFF_FALL = 8'h24;

    // PIN_CFG word layout: [15:0] sel, [16] ext_en, [17] inv
    typedef struct packed {
        logic        inv;
        logic        ext_en;
        logic [15:0] sel;
    } pin_cfg_t;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction
endpackage

// File: rtl/boa_gpio_pin_in.sv
// boa_gpio_pin_in: per-pin input conditioning (2-FF sync, invert, optional debounce) and edge detect
// Optional feature macro: GPIO_DEBOUNCE_EN (adds a debounce_len-cycle stability filter)
// Ports:
//   clk  - clock
//   rst  - synchronous reset, active-low
//   pin  - asynchronous pin input
//   inv  - invert the synchronised input
//   f    - filtered input level
//   rise - f went 0->1 this cycle
//   fall - f went 1->0 this cycle
module boa_gpio_pin_in
`ifdef GPIO_DEBOUNCE_EN
#(
    parameter int debounce_len = 16
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic pin,
    input  logic inv,
    output logic f,
    output logic rise,
    output logic fall
);
    logic s1, s2, fp;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            fp <= 1'b0;
        end else begin
            s1 <= pin;
            s2 <= s1;
            fp <= f;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    // f follows the conditioned input only after it has disagreed for debounce_len consecutive cycles
    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
            f   <= 1'b0;
        end else if ((s2 ^ inv) != f) begin
            if (cnt == 16'(debounce_len - 1)) begin
                f   <= s2 ^ inv;
                cnt <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end else begin
            cnt <= '0;
        end
    end
`else
    assign f = s2 ^ inv;
`endif

    assign rise = f & ~fp;
    assign fall = ~f & fp;
endmodule

// File: rtl/boa_peri_gpio_irq.sv
// boa_peri_gpio_irq: GPIO matrix peripheral with atomic output ops and edge interrupts on the boa_mem_bus
// Optional feature macro: GPIO_DEBOUNCE_EN (per-pin debounce filter of debounce_len cycles)
// Ports:
//   clk, rst          - clock, synchronous active-low reset
//   bus_req           - bus access strobe
//   bus_addr          - word address
//   bus_we            - byte enables (nonzero = write)
//   bus_wdata         - write data
//   bus_rdata         - registered read data, valid one cycle after the address
//   bus_ready         - always 1
//   ext, ext_oe       - external matrix signals and their output enables
//   pin_out, pin_oe   - pin output values and enables
//   pin_in            - asynchronous pin inputs
//   irq               - registered level interrupt
module boa_peri_gpio_irq
    import boa_gpio_pkg::*;
#(
    parameter logic [31:0] addr         = 32'h8000_0000,
    parameter int          pins         = 32,
    parameter int          num_ext      = 1,
    parameter int          debounce_len = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bus_req,
    input  logic [29:0]        bus_addr,
    input  logic [3:0]         bus_we,
    input  logic [31:0]        bus_wdata,
    output logic [31:0]        bus_rdata,
    output logic               bus_ready,
    input  logic [num_ext-1:0] ext,
    input  logic [num_ext-1:0] ext_oe,
    output logic [pins-1:0]    pin_out,
    output logic [pins-1:0]    pin_oe,
    input  logic [pins-1:0]    pin_in,
    output logic               irq
);
    localparam int          EW = num_ext > 1 ? $clog2(num_ext) : 1;
    localparam logic [16:0] NE = 17'(num_ext);
    localparam logic [5:0]  NP = 6'(pins);

    if (pins < 2 || pins > 32 || num_ext < 1 || num_ext > 65536 ||
        debounce_len < 2 || debounce_len > 65535) begin : g_bad_cfg
        $error("boa_peri_gpio_irq: parameter out of range");
    end

    logic [pins-1:0] out_r, oe_r, en_r, stat_r, rise_en, fall_en, f, rise, fall, wd, wm;
    pin_cfg_t        cfg [pins];
    logic            hit, wr;
    logic [7:0]      bo;
    logic [4:0]      idx;
    logic [31:0]     bm, rd;

    assign bus_ready = 1'b1;
    assign hit       = bus_req && bus_addr[29:6] == addr[31:8];
    assign wr        = hit && |bus_we;
    assign bo        = {bus_addr[5:0], 2'b00};
    assign idx       = bus_addr[4:0];
    assign bm        = lane_mask(bus_we);
    assign wm        = bm[pins-1:0];
    // write data already restricted to enabled lanes, so W1S/W1C/TGL only touch those bits
    assign wd        = bus_wdata[pins-1:0] & wm;

    for (genvar i = 0; i < pins; i++) begin : g_pin
        logic sel_ok;
        boa_gpio_pin_in
`ifdef GPIO_DEBOUNCE_EN
            #(.debounce_len(debounce_len))
`endif
            u_in (
                .clk  (clk),
                .rst  (rst),
                .pin  (pin_in[i]),
                .inv  (cfg[i].inv),
                .f    (f[i]),
                .rise (rise[i]),
                .fall (fall[i])
            );
        assign sel_ok     = {1'b0, cfg[i].sel} < NE;
        assign pin_out[i] = cfg[i].ext_en ? sel_ok & ext[cfg[i].sel[EW-1:0]] : out_r[i];
        assign pin_oe[i]  = cfg[i].ext_en ? sel_ok & ext_oe[cfg[i].sel[EW-1:0]] : oe_r[i];
    end

    always_comb begin
        rd = '0;
        if (bus_addr[5]) rd = {1'b0, idx} < NP ? 32'(cfg[idx]) : '0;
        else begin
            case (bo)
                OFF_IN:   rd = 32'(f);
                OFF_OUT:  rd = 32'(out_r);
                OFF_OE:   rd = 32'(oe_r);
                OFF_EN:   rd = 32'(en_r);
                OFF_STAT: rd = 32'(stat_r);
                OFF_RISE: rd = 32'(rise_en);
                OFF_FALL: rd = 32'(fall_en);
                default:  rd = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_r     <= '0;
            oe_r      <= '0;
            en_r      <= '0;
            stat_r    <= '0;
            rise_en   <= '0;
            fall_en   <= '0;
            bus_rdata <= '0;
            irq       <= 1'b0;
            for (int n = 0; n < pins; n++) cfg[n] <= '0;
        end else begin
            if (wr && bo == OFF_OUT)  out_r   <= (out_r & ~wm) | wd;
            if (wr && bo == OFF_SET)  out_r   <= out_r | wd;
            if (wr && bo == OFF_CLR)  out_r   <= out_r & ~wd;
            if (wr && bo == OFF_TGL)  out_r   <= out_r ^ wd;
            if (wr && bo == OFF_OE)   oe_r    <= (oe_r & ~wm) | wd;
            if (wr && bo == OFF_EN)   en_r    <= (en_r & ~wm) | wd;
            if (wr && bo == OFF_RISE) rise_en <= (rise_en & ~wm) | wd;
            if (wr && bo == OFF_FALL) fall_en <= (fall_en & ~wm) | wd;
            // a new edge in the same cycle as its W1C wins, so no event is lost
            stat_r    <= (stat_r & ~(wr && bo == OFF_STAT ? wd : '0)) | (rise & rise_en) | (fall & fall_en);
            irq       <= |(stat_r & en_r);
            bus_rdata <= hit ? rd : '0;
            for (int n = 0; n < pins; n++)
                if (wr && bus_addr[5] && idx == 5'(n))
                    cfg[n] <= pin_cfg_t'((cfg[n] & ~bm[17:0]) | (bus_wdata[17:0] & bm[17:0]));
        end
    end
endmodule

// File: tb/tb_boa_peri_gpio_irq.sv
// tb_boa_peri_gpio_irq: directed and randomized checks of boa_peri_gpio_irq against a behavioural model
module tb_boa_peri_gpio_irq;
    localparam logic [31:0] ADDR = 32'h8000_0000;
`ifdef GPIO_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 0;
`endif

    logic        clk, rst, bus_req, bus_ready, irq;
    logic [29:0] bus_addr;
    logic [3:0]  bus_we, ext, ext_oe;
    logic [31:0] bus_wdata, bus_rdata, pin_out, pin_oe, pin_in;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_out, m_oe, m_en, m_stat, m_rise, m_fall, m_prev;
    logic [15:0] m_sel [32];
    logic        m_ext_en [32];
    logic        m_inv [32];
    logic [7:0]  rw_off [5] = '{8'h04, 8'h14, 8'h18, 8'h20, 8'h24};
    logic [7:0]  zero_off [12] = '{8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24, 8'h80, 8'h8C, 8'hFC};

    logic [31:0] d, rv, m;
    logic [3:0]  be;
    logic [7:0]  off;
    logic [15:0] sel;
    logic        e, v;
    int          k, n;

    boa_peri_gpio_irq #(
        .addr         (ADDR),
        .pins         (32),
        .num_ext      (4),
        .debounce_len (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_req   (bus_req),
        .bus_addr  (bus_addr),
        .bus_we    (bus_we),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .ext       (ext),
        .ext_oe    (ext_oe),
        .pin_out   (pin_out),
        .pin_oe    (pin_oe),
        .pin_in    (pin_in),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] o, input logic [31:0] dat, input logic [3:0] b);
        @(posedge clk); #1;
        bus_req = 1'b1; bus_addr = {ADDR[31:8], o[7:2]}; bus_we = b; bus_wdata = dat;
        @(posedge clk); #1;
        bus_req = 1'b0; bus_we = 4'h0;
    endtask

    task automatic rd(input logic [7:0] o, output logic [31:0] dat);
        @(posedge clk); #1;
        bus_req = 1'b1; bus_addr = {ADDR[31:8], o[7:2]}; bus_we = 4'h0;
        @(posedge clk); #1;
        dat = bus_rdata; bus_req = 1'b0;
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] b);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = {8{b[i]}};
        return r;
    endfunction

    function automatic logic [31:0] inv_mask();
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = m_inv[i];
        return r;
    endfunction

    function automatic logic [31:0] exp_pins(input logic want_oe);
        logic [31:0] r;
        for (int i = 0; i < 32; i++)
            if (m_ext_en[i]) r[i] = m_sel[i] < 16'd4 ? (want_oe ? ext_oe[m_sel[i][1:0]] : ext[m_sel[i][1:0]]) : 1'b0;
            else r[i] = want_oe ? m_oe[i] : m_out[i];
        return r;
    endfunction

    // let inputs propagate, then account for the single level change each pin has seen
    task automatic settle();
        logic [31:0] nf;
        repeat (8 + DB) @(posedge clk);
        #1;
        nf     = pin_in ^ inv_mask();
        m_stat = m_stat | (nf & ~m_prev & m_rise) | (~nf & m_prev & m_fall);
        m_prev = nf;
    endtask

    initial begin
        rst = 1'b0; bus_req = 1'b0; bus_addr = '0; bus_we = 4'h0; bus_wdata = '0;
        ext = 4'h0; ext_oe = 4'h0; pin_in = 32'hFFFF_FFFF;
        // reset with inputs high and a read in flight
        @(posedge clk); #1;
        bus_req = 1'b1; bus_addr = {ADDR[31:8], 6'h00};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pin_out", pin_out, 32'h0);
        chk("rst_pin_oe", pin_oe, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_rdata", bus_rdata, 32'h0);
        bus_req = 1'b0; rst = 1'b1;
        repeat (4 + DB) @(posedge clk);
        for (int i = 0; i < 12; i++) begin
            rd(zero_off[i], rv);
            chk($sformatf("rst_reg_%h", zero_off[i]), rv, 32'h0);
        end
        rd(8'h00, rv);
        chk("rst_in_high", rv, 32'hFFFF_FFFF);
        chk("rst_irq_after", {31'h0, irq}, 32'h0);
        pin_in = 32'h0;
        repeat (8 + DB) @(posedge clk);

        // atomic output ops and byte-lane writes
        wr(8'h04, 32'h0000_00F0, 4'hF);
        wr(8'h08, 32'h0000_000F, 4'hF);
        wr(8'h0C, 32'h0000_0030, 4'hF);
        wr(8'h10, 32'h0000_0101, 4'hF);
        rd(8'h04, rv);
        chk("out_atomic", rv, 32'h0000_01CE);
        chk("pin_out_atomic", pin_out, 32'h0000_01CE);
        wr(8'h04, 32'hAAAA_AAAA, 4'b0001);
        rd(8'h04, rv);
        chk("out_lane0", rv, 32'h0000_01AA);
        rd(8'h08, rv);
        chk("set_reads0", rv, 32'h0);
        rd(8'h10, rv);
        chk("tgl_reads0", rv, 32'h0);
        wr(8'h08, 32'hFFFF_FFFF, 4'b0100);
        rd(8'h04, rv);
        chk("set_lane2", rv, 32'h00FF_01AA);

        // external matrix routing
        wr(8'h04, 32'h0, 4'hF);
        ext = 4'b0100; ext_oe = 4'b0100;
        wr(8'h8C, 32'h0001_0002, 4'hF);
        #1;
        chk("ext_pin_out", pin_out, 32'h0000_0008);
        chk("ext_pin_oe", pin_oe, 32'h0000_0008);
        ext = 4'b1011; ext_oe = 4'b1011;
        #1;
        chk("ext_pin_out_lo", pin_out, 32'h0);
        ext = 4'b1111; ext_oe = 4'b1111;
        wr(8'h8C, 32'hFFFD_0007, 4'hF);
        #1;
        chk("ext_sel7_out", pin_out, 32'h0);
        chk("ext_sel7_oe", pin_oe, 32'h0);
        rd(8'h8C, rv);
        chk("cfg3_read", rv, 32'h0001_0007);

        // rising-edge interrupt latency on pin 5
        wr(8'h20, 32'h20, 4'hF);
        wr(8'h18, 32'h20, 4'hF);
        @(posedge clk); #1;
        pin_in[5] = 1'b1;
        repeat (1 + DB) @(posedge clk);
        #1;
        bus_req = 1'b1; bus_we = 4'h0; bus_addr = {ADDR[31:8], 6'h00};
        @(posedge clk); #1;
        chk("in_before", bus_rdata, 32'h0);
        @(posedge clk); #1;
        chk("in_after", bus_rdata, 32'h20);
        chk("irq_k3", {31'h0, irq}, 32'h0);
        bus_addr = {ADDR[31:8], 6'h07};
        @(posedge clk); #1;
        chk("stat_k4", bus_rdata, 32'h20);
        chk("irq_k4", {31'h0, irq}, 32'h1);
        bus_req = 1'b0;
        wr(8'h1C, 32'h20, 4'hF);
        chk("irq_w1c_1", {31'h0, irq}, 32'h1);
        @(posedge clk); #1;
        chk("irq_w1c_2", {31'h0, irq}, 32'h0);
        rd(8'h1C, rv);
        chk("stat_cleared", rv, 32'h0);

        // W1C collides with a fresh rising edge
        pin_in[5] = 1'b0;
        repeat (8 + DB) @(posedge clk);
        pin_in[5] = 1'b1;
        repeat (8 + DB) @(posedge clk);
        #1;
        chk("irq_again", {31'h0, irq}, 32'h1);
        pin_in[5] = 1'b0;
        repeat (8 + DB) @(posedge clk);
        @(posedge clk); #1;
        pin_in[5] = 1'b1;
        repeat (2 + DB) @(posedge clk);
        #1;
        bus_req = 1'b1; bus_addr = {ADDR[31:8], 6'h07}; bus_we = 4'hF; bus_wdata = 32'h20;
        @(posedge clk); #1;
        bus_req = 1'b0; bus_we = 4'h0;
        chk("irq_collide", {31'h0, irq}, 32'h1);
        rd(8'h1C, rv);
        chk("stat_collide", rv, 32'h20);
        chk("irq_collide_2", {31'h0, irq}, 32'h1);

`ifdef GPIO_DEBOUNCE_EN
        wr(8'h20, 32'h21, 4'hF);
        @(posedge clk); #1;
        pin_in[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        pin_in[0] = 1'b0;
        repeat (12) @(posedge clk);
        rd(8'h00, rv);
        chk("db_glitch_in", rv & 32'h1, 32'h0);
        rd(8'h1C, rv);
        chk("db_glitch_stat", rv, 32'h20);
        @(posedge clk); #1;
        pin_in[0] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus_req = 1'b1; bus_addr = {ADDR[31:8], 6'h00};
        @(posedge clk); #1;
        chk("db_in_k6", bus_rdata & 32'h1, 32'h0);
        @(posedge clk); #1;
        chk("db_in_k7", bus_rdata & 32'h1, 32'h1);
        bus_req = 1'b0;
        repeat (4) @(posedge clk);
        rd(8'h1C, rv);
        chk("db_stat", rv, 32'h21);
`endif

        // reset mid-transaction: the write held during reset must not land
        @(posedge clk); #1;
        rst = 1'b0;
        bus_req = 1'b1; bus_addr = {ADDR[31:8], 6'h01}; bus_we = 4'hF; bus_wdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst2_irq", {31'h0, irq}, 32'h0);
        chk("rst2_pin_out", pin_out, 32'h0);
        bus_req = 1'b0; bus_we = 4'h0; rst = 1'b1;
        rd(8'h04, rv);
        chk("rst2_out", rv, 32'h0);
        rd(8'h8C, rv);
        chk("rst2_cfg3", rv, 32'h0);

        m_out = 0; m_oe = 0; m_en = 0; m_stat = 0; m_rise = 0; m_fall = 0; m_prev = 0;
        for (int i = 0; i < 32; i++) begin m_sel[i] = 0; m_ext_en[i] = 0; m_inv[i] = 0; end
        pin_in = $urandom;
        settle();

        for (int it = 0; it < 60; it++) begin
            d  = $urandom;
            be = 4'($urandom);
            m  = bmask(be);
            case ($urandom_range(0, 6))
                0: begin
                    k = $urandom_range(0, 4);
                    wr(rw_off[k], d, be);
                    case (k)
                        0: m_out  = (m_out & ~m) | (d & m);
                        1: m_oe   = (m_oe & ~m) | (d & m);
                        2: m_en   = (m_en & ~m) | (d & m);
                        3: m_rise = (m_rise & ~m) | (d & m);
                        default: m_fall = (m_fall & ~m) | (d & m);
                    endcase
                end
                1: begin
                    k = $urandom_range(0, 2);
                    wr(8'h08 + 8'(4 * k), d, be);
                    m_out = k == 0 ? m_out | (d & m) : k == 1 ? m_out & ~(d & m) : m_out ^ (d & m);
                end
                2: begin
                    wr(8'h1C, d, be);
                    m_stat = m_stat & ~(d & m);
                end
                3: pin_in = $urandom;
                4: begin
                    n   = $urandom_range(0, 7);
                    sel = 16'($urandom_range(0, 7));
                    e   = 1'($urandom_range(0, 1));
                    v   = 1'($urandom_range(0, 1));
                    wr(8'h80 + 8'(4 * n), {14'($urandom), v, e, sel}, 4'hF);
                    m_sel[n] = sel; m_ext_en[n] = e; m_inv[n] = v;
                    rd(8'h80 + 8'(4 * n), rv);
                    chk("r_cfg", rv, {14'h0, v, e, sel});
                end
                5: begin
                    ext    = 4'($urandom);
                    ext_oe = 4'($urandom);
                end
                default: begin
                    off = 8'h28 + 8'(4 * $urandom_range(0, 21));
                    wr(off, d, 4'hF);
                    rd(off, rv);
                    chk("r_unmapped", rv, 32'h0);
                end
            endcase
            settle();
            rd(8'h00, rv); chk("r_in", rv, m_prev);
            rd(8'h04, rv); chk("r_out", rv, m_out);
            rd(8'h14, rv); chk("r_oe", rv, m_oe);
            rd(8'h1C, rv); chk("r_stat", rv, m_stat);
            rd(8'h20, rv); chk("r_rise", rv, m_rise);
            rd(8'h24, rv); chk("r_fall", rv, m_fall);
            chk("r_pin_out", pin_out, exp_pins(1'b0));
            chk("r_pin_oe", pin_oe, exp_pins(1'b1));
            chk("r_irq", {31'h0, irq}, {31'h0, |(m_stat & m_en)});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
